// File: rtl/apb_arbiter.sv
// N-to-1 APB arbiter: merges several APB initiators onto one APB target, one transfer at a time.
// Optional macro APB_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
`timescale 1ns/1ps

module apb_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int W_ADDR    = 16,
  parameter int W_DATA    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*W_ADDR-1:0]   apbs_paddr,
  input  logic [N_MASTERS-1:0]          apbs_psel,
  input  logic [N_MASTERS-1:0]          apbs_penable,
  input  logic [N_MASTERS-1:0]          apbs_pwrite,
  input  logic [N_MASTERS*W_DATA-1:0]   apbs_pwdata,
  output logic [N_MASTERS-1:0]          apbs_pready,
  output logic [N_MASTERS*W_DATA-1:0]   apbs_prdata,
  output logic [N_MASTERS-1:0]          apbs_pslverr,
  output logic [W_ADDR-1:0]             apbm_paddr,
  output logic                          apbm_psel,
  output logic                          apbm_penable,
  output logic                          apbm_pwrite,
  output logic [W_DATA-1:0]             apbm_pwdata,
  input  logic                          apbm_pready,
  input  logic [W_DATA-1:0]             apbm_prdata,
  input  logic                          apbm_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [N_MASTERS-1:0]   grant;
  logic [N_MASTERS-1:0]   grant_next;
  logic [N_MASTERS-1:0]   winner;
  logic [N_MASTERS-1:0]   live_grant;
  logic                   in_setup;
  logic                   in_access;
  logic                   unused_penable;

  // Only psel requests service; penable is part of the upstream handshake, not arbitration.
  assign unused_penable = ^apbs_penable;

`ifdef APB_ARBITER_ROUND_ROBIN_EN
  localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [PTR_W-1:0] start_ptr;
  logic [PTR_W-1:0] start_ptr_next;

  // Winner is the requester with the smallest rotated distance from start_ptr.
  always_comb begin
    int   dist;
    logic found;
    winner         = '0;
    start_ptr_next = start_ptr;
    found          = 1'b0;
    dist           = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        dist = i - int'(start_ptr);
        if (dist < 0) dist = dist + N_MASTERS;
        if (!found && apbs_psel[i] && (dist == k)) begin
          found          = 1'b1;
          winner[i]      = 1'b1;
          start_ptr_next = (i == N_MASTERS - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_ptr <= '0;
    end else if ((state == IDLE) && (|apbs_psel)) begin
      start_ptr <= start_ptr_next;
    end
  end
`else
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!found && apbs_psel[i]) begin
        found     = 1'b1;
        winner[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  // Grant is loaded only from IDLE, so late requests wait for the next IDLE cycle.
  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (|apbs_psel) begin
          grant_next = winner;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (apbm_pready) begin
          grant_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, even mid-transfer.
  assign in_setup   = (state == SETUP)  && !rst;
  assign in_access  = (state == ACCESS) && !rst;
  assign live_grant = rst ? '0 : grant;

  assign apbm_psel    = in_setup | in_access;
  assign apbm_penable = in_access;
  assign apbs_pready  = live_grant & {N_MASTERS{in_access & apbm_pready}};
  assign apbs_pslverr = live_grant & {N_MASTERS{in_access & apbm_pready & apbm_pslverr}};

  always_comb begin
    apbm_paddr  = '0;
    apbm_pwrite = 1'b0;
    apbm_pwdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (live_grant[i]) begin
        apbm_paddr  = apbm_paddr  | apbs_paddr[i*W_ADDR +: W_ADDR];
        apbm_pwrite = apbm_pwrite | apbs_pwrite[i];
        apbm_pwdata = apbm_pwdata | apbs_pwdata[i*W_DATA +: W_DATA];
      end
    end
  end

  always_comb begin
    apbs_prdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (live_grant[i]) apbs_prdata[i*W_DATA +: W_DATA] = apbm_prdata;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration model and scoreboard. Honours APB_ARBITER_ROUND_ROBIN_EN.
`timescale 1ns/1ps

module tb_apb_arbiter;
  localparam int N  = 2;
  localparam int WA = 16;
  localparam int WD = 32;

  typedef struct packed {
    logic [7:0]    id;
    logic [WA-1:0] addr;
    logic          wr;
    logic [WD-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*WA-1:0]   apbs_paddr;
  logic [N-1:0]      apbs_psel;
  logic [N-1:0]      apbs_penable;
  logic [N-1:0]      apbs_pwrite;
  logic [N*WD-1:0]   apbs_pwdata;
  logic [N-1:0]      apbs_pready;
  logic [N*WD-1:0]   apbs_prdata;
  logic [N-1:0]      apbs_pslverr;
  logic [WA-1:0]     apbm_paddr;
  logic              apbm_psel;
  logic              apbm_penable;
  logic              apbm_pwrite;
  logic [WD-1:0]     apbm_pwdata;
  logic              apbm_pready;
  logic [WD-1:0]     apbm_prdata;
  logic              apbm_pslverr;

  logic [WA-1:0] m_addr    [N];
  logic          m_psel    [N];
  logic          m_penable [N];
  logic          m_wr      [N];
  logic [WD-1:0] m_wdata   [N];

  logic          man_en = 1'b1;
  logic          man_pready = 1'b0;
  logic [WD-1:0] man_prdata = '0;
  logic          man_pslverr = 1'b0;
  logic          tgt_pready = 1'b0;
  logic [WD-1:0] tgt_prdata = '0;
  logic          tgt_pslverr = 1'b0;

  logic sb_en = 1'b0;
  int   checks = 0;
  int   passed = 0;

  txn_t pend_q[$];
  txn_t exp_ds[$];
  int   order_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      apbs_paddr[i*WA +: WA] = m_addr[i];
      apbs_psel[i]           = m_psel[i];
      apbs_penable[i]        = m_penable[i];
      apbs_pwrite[i]         = m_wr[i];
      apbs_pwdata[i*WD +: WD] = m_wdata[i];
    end
  end

  assign apbm_pready  = man_en ? man_pready  : tgt_pready;
  assign apbm_prdata  = man_en ? man_prdata  : tgt_prdata;
  assign apbm_pslverr = man_en ? man_pslverr : tgt_pslverr;

  apb_arbiter #(.N_MASTERS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk(clk), .rst(rst),
    .apbs_paddr(apbs_paddr), .apbs_psel(apbs_psel), .apbs_penable(apbs_penable),
    .apbs_pwrite(apbs_pwrite), .apbs_pwdata(apbs_pwdata), .apbs_pready(apbs_pready),
    .apbs_prdata(apbs_prdata), .apbs_pslverr(apbs_pslverr),
    .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
    .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata), .apbm_pready(apbm_pready),
    .apbm_prdata(apbm_prdata), .apbm_pslverr(apbm_pslverr)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int id, input logic [WA-1:0] addr, input logic wr, input logic [WD-1:0] wdata);
    txn_t t;
    m_psel[id] = 1'b1; m_penable[id] = 1'b0;
    m_addr[id] = addr; m_wr[id] = wr; m_wdata[id] = wdata;
    t.id = 8'(id); t.addr = addr; t.wr = wr; t.wdata = wdata;
    if (sb_en) pend_q.push_back(t);
  endtask

  task automatic release_master(input int id);
    m_psel[id] = 1'b0; m_penable[id] = 1'b0;
    m_addr[id] = '0; m_wr[id] = 1'b0; m_wdata[id] = '0;
  endtask

  task automatic check_all_quiet(input string name);
    check_output({name, "_psel"}, {62'd0, apbm_psel, apbm_penable}, 64'd0);
    check_output({name, "_dsbus"}, {15'd0, apbm_pwrite, apbm_paddr, apbm_pwdata}, 64'd0);
    check_output({name, "_usresp"}, {60'd0, apbs_pready, apbs_pslverr}, 64'd0);
    check_output({name, "_prdata"}, apbs_prdata, 64'd0);
  endtask

  // Autonomous APB initiator; idle of zero keeps psel high into the next setup phase.
  task automatic master_run(input int id, input int n_txn, input int max_idle);
    int budget;
    logic done;
    int idle;
    next_cycle();
    for (int t = 0; t < n_txn; t++) begin
      idle = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
      if (idle > 0) begin
        release_master(id);
        repeat (idle) next_cycle();
      end
      apply_stimulus(id, WA'($urandom), 1'($urandom), $urandom);
      next_cycle();
      m_penable[id] = 1'b1;
      done = 1'b0;
      budget = 0;
      while (!done && budget < 2000) begin
        @(negedge clk);
        budget++;
        if (apbs_pready[id]) done = 1'b1;
      end
      check_output("master_done", {63'd0, done}, 64'd1);
      next_cycle();
    end
    release_master(id);
  endtask

  function automatic int pick(input int rr_next);
`ifdef APB_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (m_psel[(rr_next + k) % N]) return (rr_next + k) % N;
`else
    for (int i = 0; i < N; i++) if (m_psel[i]) return i;
`endif
    return 0;
  endfunction

  // Random target: response chosen each cycle, pready only while an access is shown.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tgt_prdata  = $urandom;
      tgt_pslverr = 1'($urandom);
      tgt_pready  = (apbm_psel && apbm_penable) ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Transaction-level model: arbitrate in idle, setup next cycle, access until target ready.
  initial begin
    logic busy;
    int   cyc, arb_cyc, cur_w, rr_next, w, idx;
    txn_t cur_t;
    busy = 1'b0; cyc = 0; arb_cyc = 0; cur_w = 0; rr_next = 0; cur_t = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 1'b0;
        rr_next = 0;
      end else if (sb_en) begin
        if (!busy) begin
          check_output("sb_idle_psel", {63'd0, apbm_psel}, 64'd0);
          if (m_psel[0] || m_psel[1]) begin
            w = pick(rr_next);
            idx = -1;
            foreach (pend_q[j]) if (idx < 0 && int'(pend_q[j].id) == w) idx = j;
            check_output("sb_pending_txn", {63'd0, idx >= 0}, 64'd1);
            if (idx >= 0) begin
              exp_ds.push_back(pend_q[idx]);
              pend_q.delete(idx);
            end
            busy = 1'b1; arb_cyc = cyc; cur_w = w; rr_next = (w + 1) % N;
          end
        end else if (cyc == arb_cyc + 1) begin
          if (exp_ds.size() > 0) cur_t = exp_ds.pop_front();
          check_output("sb_setup_phase", {62'd0, apbm_psel, apbm_penable}, 64'd2);
          check_output("sb_setup_bus", {apbm_pwrite, apbm_paddr, apbm_pwdata},
                       {cur_t.wr, cur_t.addr, cur_t.wdata});
          check_output("sb_setup_pready", {62'd0, apbs_pready}, 64'd0);
        end else begin
          check_output("sb_access_phase", {62'd0, apbm_psel, apbm_penable}, 64'd3);
          check_output("sb_access_bus", {apbm_pwrite, apbm_paddr, apbm_pwdata},
                       {cur_t.wr, cur_t.addr, cur_t.wdata});
          if (tgt_pready) begin
            check_output("sb_done_pready", {62'd0, apbs_pready}, 64'(1 << cur_w));
            check_output("sb_done_pslverr", {62'd0, apbs_pslverr}, tgt_pslverr ? 64'(1 << cur_w) : 64'd0);
            check_output("sb_done_prdata", apbs_prdata, 64'(tgt_prdata) << (cur_w * WD));
            order_q.push_back(apbs_pready[1] ? 1 : 0);
            busy = 1'b0;
          end else begin
            check_output("sb_wait_pready", {62'd0, apbs_pready}, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    for (int i = 0; i < N; i++) release_master(i);

    // Reset: outputs quiet with a nonzero target response present.
    man_prdata = 32'hDEADBEEF; man_pready = 1'b1; man_pslverr = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check_all_quiet("reset_held");
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_all_quiet("reset_released");

    // Single master read, zero-wait target.
    man_prdata = 32'hCAFEF00D; man_pready = 1'b1; man_pslverr = 1'b0;
    next_cycle();
    apply_stimulus(0, 16'h1234, 1'b0, 32'h0);
    @(negedge clk);
    check_output("rd_t0_psel", {63'd0, apbm_psel}, 64'd0);
    next_cycle();
    m_penable[0] = 1'b1;
    @(negedge clk);
    check_output("rd_t1_phase", {62'd0, apbm_psel, apbm_penable}, 64'd2);
    check_output("rd_t1_addr", 64'(apbm_paddr), 64'h1234);
    check_output("rd_t1_pready", {62'd0, apbs_pready}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("rd_t2_phase", {62'd0, apbm_psel, apbm_penable}, 64'd3);
    check_output("rd_t2_pready", {62'd0, apbs_pready}, 64'd1);
    check_output("rd_t2_prdata", apbs_prdata, 64'h0000_0000_CAFE_F00D);
    next_cycle();
    release_master(0);
    @(negedge clk);
    check_all_quiet("rd_t3_idle");

    // Write with three wait states from master 1.
    man_pready = 1'b0;
    next_cycle();
    apply_stimulus(1, 16'h0040, 1'b1, 32'h55AA);
    next_cycle();
    m_penable[1] = 1'b1;
    @(negedge clk);
    check_output("wr_setup_bus", {apbm_pwrite, apbm_paddr, apbm_pwdata}, {1'b1, 16'h0040, 32'h55AA});
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      man_pready = (j == 3);
      @(negedge clk);
      check_output("wr_wait_pwdata", 64'(apbm_pwdata), 64'h55AA);
      check_output("wr_wait_m0_pready", {63'd0, apbs_pready[0]}, 64'd0);
      pulses += int'(apbs_pready[1]);
    end
    check_output("wr_pready_pulses", 64'(pulses), 64'd1);
    next_cycle();
    release_master(1);
    man_pready = 1'b0;

    // Error response to master 1.
    man_pready = 1'b1; man_pslverr = 1'b1;
    next_cycle();
    apply_stimulus(1, 16'h0080, 1'b0, 32'h0);
    next_cycle();
    m_penable[1] = 1'b1;
    @(negedge clk);
    check_output("err_setup_pslverr", {62'd0, apbs_pslverr}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("err_done_pslverr", {62'd0, apbs_pslverr}, 64'd2);
    check_output("err_done_pready", {62'd0, apbs_pready}, 64'd2);
    next_cycle();
    release_master(1);
    man_pslverr = 1'b0; man_pready = 1'b0;
    @(negedge clk);
    check_output("err_after_pslverr", {62'd0, apbs_pslverr}, 64'd0);

    // Reset mid-access with master 1 pending.
    next_cycle();
    apply_stimulus(0, 16'h0100, 1'b0, 32'h0);
    next_cycle();
    m_penable[0] = 1'b1;
    next_cycle();
    @(negedge clk);
    check_output("rst_pre_penable", {63'd0, apbm_penable}, 64'd1);
    next_cycle();
    rst = 1'b1;
    release_master(0);
    apply_stimulus(1, 16'h0200, 1'b0, 32'h0);
    @(negedge clk);
    check_output("rst_during_phase", {62'd0, apbm_psel, apbm_penable}, 64'd0);
    next_cycle();
    rst = 1'b0;
    m_penable[1] = 1'b1;
    @(negedge clk);
    check_all_quiet("rst_after");
    next_cycle();
    @(negedge clk);
    check_output("rst_regrant_phase", {62'd0, apbm_psel, apbm_penable}, 64'd2);
    check_output("rst_regrant_addr", 64'(apbm_paddr), 64'h0200);
    next_cycle();
    man_pready = 1'b1;
    @(negedge clk);
    check_output("rst_regrant_pready", {62'd0, apbs_pready}, 64'd2);
    next_cycle();
    release_master(1);
    man_pready = 1'b0;

    // Contention: both masters request back to back, four transfers each.
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    man_en = 1'b0;
    sb_en = 1'b1;
    order_q.delete();
    fork
      master_run(0, 4, 0);
      master_run(1, 4, 0);
    join
    repeat (3) next_cycle();
    check_output("contend_count", 64'(order_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < order_q.size(); k++) begin
`ifdef APB_ARBITER_ROUND_ROBIN_EN
      check_output("contend_order", 64'(order_q[k]), 64'(k % 2));
`else
      check_output("contend_order", 64'(order_q[k]), (k < 4) ? 64'd0 : 64'd1);
`endif
    end

    // Randomized traffic against the model.
    fork
      master_run(0, 25, 3);
      master_run(1, 25, 3);
    join
    repeat (5) next_cycle();
    check_output("drain_pending", 64'(pend_q.size() + exp_ds.size()), 64'd0);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
